// File: rtl/seg_mux_bcd_disp.sv
// seg_mux_bcd_disp: 4-digit time-multiplexed common-anode seven-segment driver with a per-frame
// snapshot of the BCD inputs. Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_mux_bcd_disp #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);
  localparam int QW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(REFRESH_DIV - 1);

  // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 shows a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 7'h40;
      4'd1:    bcd_to_seg = 7'h79;
      4'd2:    bcd_to_seg = 7'h24;
      4'd3:    bcd_to_seg = 7'h30;
      4'd4:    bcd_to_seg = 7'h19;
      4'd5:    bcd_to_seg = 7'h12;
      4'd6:    bcd_to_seg = 7'h02;
      4'd7:    bcd_to_seg = 7'h78;
      4'd8:    bcd_to_seg = 7'h00;
      4'd9:    bcd_to_seg = 7'h10;
      default: bcd_to_seg = 7'h3F;
    endcase
  endfunction

  logic [QW-1:0] q_q, q_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, sdp_q, sdp_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    sseg_q, sseg_d;
  logic          q_wrap, frame_end, blank1, blank2;
  logic [6:0]    segs;

  always_comb begin
    q_wrap    = (q_q == Q_LAST);
    frame_end = q_wrap && (idx_q == 2'd3);
    q_d       = q_wrap ? '0 : q_q + QW'(1);
    idx_d     = q_wrap ? idx_q + 2'd1 : idx_q;

    s0_d  = s0_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    sdp_d = sdp_q;
    if (frame_end) begin
      s0_d  = d0;
      s1_d  = d1;
      s2_d  = d2;
      sdp_d = dp_in;
    end

`ifdef SEG_LZB_EN
    blank2 = (s2_q == 4'd0) && !sdp_q[2];
    blank1 = blank2 && (s1_q == 4'd0) && !sdp_q[1];
`else
    blank2 = 1'b0;
    blank1 = 1'b0;
`endif

    // Position 3 has no digit source; only its decimal point can light.
    case (idx_q)
      2'd0:    segs = bcd_to_seg(s0_q);
      2'd1:    segs = blank1 ? 7'h7F : bcd_to_seg(s1_q);
      2'd2:    segs = blank2 ? 7'h7F : bcd_to_seg(s2_q);
      default: segs = 7'h7F;
    endcase

    an_d   = ~(4'b0001 << idx_q);
    sseg_d = {~sdp_q[idx_q], segs};
  end

  // Scan state, snapshot and registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      idx_q  <= 2'd0;
      s0_q   <= 4'd0;
      s1_q   <= 4'd0;
      s2_q   <= 4'd0;
      sdp_q  <= 4'd0;
      an_q   <= 4'hF;
      sseg_q <= 8'hFF;
    end else begin
      q_q    <= q_d;
      idx_q  <= idx_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      sdp_q  <= sdp_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = frame_end && !reset;
endmodule

// File: doc/seg_mux_bcd_disp.md
# seg_mux_bcd_disp

Time-multiplexed 4-digit seven-segment driver that consumes the 3-digit BCD count from the stopwatch (d2 d1 d0, 0.1 s resolution) and drives the common-anode board display. It snapshots all digits once per scan frame so a count change never tears mid-frame. It scans digits at a fixed refresh rate, decodes BCD to segments, and inserts decimal points. It sits between the stopwatch counter and the board anode/segment pins.

## Interface
- REFRESH_DIV, 50000: clk cycles each digit is lit; legal range 2..2^20.
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- d2  in  4  BCD hundreds digit (10 s units).
- d1  in  4  BCD tens digit (1 s units).
- d0  in  4  BCD units digit (0.1 s units).
- dp_in  in  4  decimal-point enable per digit position; bit k goes to digit k.
- an  out  4  anode enables, active-low; an[0] is the rightmost digit.
- sseg  out  8  segments, active-low: {dp,g,f,e,d,c,b,a}.
- frame_tick  out  1  one-cycle pulse marking the frame boundary and snapshot capture.

## Operation
- Prescaler q: 0..REFRESH_DIV-1; wraps to 0. Width is clog2(REFRESH_DIV).
- Digit index idx: 2 bits, order 0,1,2,3,0…; advances on the cycle after q==REFRESH_DIV-1.
- Snapshot registers s0,s1,s2 and sdp: capture d0,d1,d2,dp_in on the cycle where q==REFRESH_DIV-1 and idx==3. The new values take effect with idx=0. Inputs never affect the display between captures.
- Position 3 has no BCD source: segments a–g are always off, and only sdp[3] can light it. It is still scanned for a uniform 25 % duty cycle.
- Decode of a value 0–9 to segments a–g uses the standard patterns; for example 0→g off, 1→b,c only, 8→all on.
- A value of 10–15 shows "-" (segment g only).
- Decimal point: sseg[7] = ~sdp[idx].
- an is one-hot low: an[idx]=0, the others are 1.
- frame_tick = (q==REFRESH_DIV-1) && (idx==3). It is high in the same cycle as the capture.

## Timing
- Reset values: q=0, idx=0, s0/s1/s2=0, sdp=0, an=4'b1111, sseg=8'hFF, frame_tick=0.
- an and sseg are registered: they reflect idx and the snapshot one cycle after idx changes.
- First cycle after reset is released: an=4'b1111. The next cycle gives an=4'b1110 with digit 0 from the reset snapshot (zeros).
- Each digit is lit for exactly REFRESH_DIV cycles. A frame is 4*REFRESH_DIV cycles.
- Input-to-display latency: up to one frame plus one cycle. After a capture, the new digit 0 appears one cycle later.
- Inputs changing in the capture cycle itself: the value present at that clk edge is taken.
- Reset asserted mid-frame: all state returns to reset values on the next edge, and the display blanks (an=4'b1111) for that cycle. Priority is reset > capture > scan.
- There is never more than one an bit low in any cycle.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking, evaluated on the snapshot.
  - Digit 2 is blanked (a–g off) if s2==0 and sdp[2]==0.
  - Digit 1 is blanked if digit 2 is blanked, s1==0 and sdp[1]==0.
  - Digit 0 is never blanked.
  - The dp bit is unaffected.
- SEG_LZB_EN undefined: all of digits 0–2 always show their decoded value. Zeros display as "0".

## Test plan
- Reset, then run 20 cycles with REFRESH_DIV=4 -> an=1111 and sseg=FF during reset. The first frame shows "0" on digits 0–2 and digit 3 is blank. Each an bit is low for exactly 4 cycles; frame_tick pulses at cycle 16 after release.
- d2/d1/d0=1/2/3 and dp_in=0010, applied mid-frame -> the display is unchanged until frame_tick. The next frame shows an=1110 with sseg=8'hB0 ("3"), an=1101 with sseg=8'h24 ("2." dp on), and an=1011 with sseg=8'hF9 ("1").
- d0=4'hC -> digit 0 shows sseg=8'hBF ("-").
- Input changes every cycle from a stopwatch model -> no change within a frame. The snapshot equals the inputs sampled at the frame_tick edge.
- With SEG_LZB_EN, inputs 0/0/5 and dp_in=0 -> digits 2 and 1 have sseg=FF and digit 0 shows "5". With inputs 0/0/5 and dp_in=0010, digit 1 shows "0.".
- Reset asserted for 1 cycle at idx=2 -> next cycle an=1111. After that the scan restarts at idx=0 with zeroed snapshot and no stray frame_tick.
